data_bus_responder: RTL
=======================

# data_bus_responder

Responder for the CPU data-memory port: decodes the CPU's data address, write-enable and write data, serves a 256-word data RAM and a small memory-mapped I/O page, and returns registered read data to the CPU's data input. Sits between the CPU and the rest of the system in place of the bare data memory. Adds GPIO output, a 32-bit cycle counter, and a TX FIFO drained through a valid/ready stream port.

## Interface
- RAM_AW, 8: RAM word-address width; RAM occupies 0x0000 to 2^RAM_AW-1.
- IO_BASE, 16'hFF00: base of I/O page.
- FIFO_DEPTH, 4: TX FIFO entries (power of 2, ≤8).
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_wr_en  in  1  CPU write strobe, qualifies mem_addr/mem_wdata this cycle.
- mem_addr  in  16  CPU data word address.
- mem_wdata  in  16  CPU write data.
- mem_rdata  out  16  read data for the address presented in the previous cycle.
- gpio_out  out  16  GPIO output register.
- tx_data  out  16  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts tx_data when tx_valid & tx_ready.

## Operation
- Address map: RAM 0x0000..2^RAM_AW-1; IO_BASE+0 GPIO (R/W); +1 CNT_LO (RO); +2 CNT_HI shadow (RO); +3 STATUS (R/W1C); +4 TXDATA (WO, reads 0). Everything else unmapped.
- RAM: written when mem_wr_en and address in RAM range. Contents not reset. Same-cycle read and write of one address returns old data (read-first).
- GPIO: write loads mem_wdata; reads return the current value.
- Counter: 32-bit free-running, +1 every cycle, wraps 0xFFFFFFFF→0. Reading CNT_LO returns the low half and, on the same edge, copies the high half into the CNT_HI shadow; CNT_HI returns the shadow. Writes to +1/+2 are ignored.
- TX FIFO: a write to TXDATA pushes mem_wdata when the count at cycle start < FIFO_DEPTH. Otherwise the word is dropped and ovf is set, even if a pop occurs that cycle. A pop happens when tx_valid & tx_ready. A push and a pop in the same cycle both take effect, leaving the count unchanged. The FIFO is circular, and pointers wrap modulo FIFO_DEPTH.
- STATUS bits:
  - [0] empty
  - [1] full
  - [2] ovf (sticky)
  - [3] bad_addr (sticky)
  - [7:4] count
  - [15:8] zero
- Writing 1 to bit 2 or 3 clears that bit. If a set event and a clear occur in the same cycle, set wins.
- Unmapped access: reads return 0. A write is ignored and sets bad_addr.
- Read-data mux: the address is decoded every cycle, since there is no read strobe. Reads have no side effects except the CNT_LO shadow capture, which happens whenever mem_addr==IO_BASE+1 and mem_wr_en=0.

## Timing
- Read latency is 1 cycle: mem_rdata at edge N+1 reflects mem_addr at edge N.
- Writes take effect at the edge where mem_wr_en=1.
- The counter value read is the value before that edge's increment.
- tx_data and tx_valid are driven directly from FIFO state, with no added latency. A pushed word is visible on tx_valid the cycle after the push.
- Reset values:
  - mem_rdata=0, gpio_out=0, tx_data=0 (head of empty FIFO reads 0), tx_valid=0.
  - Counter=0, shadow=0, pointers/count=0, ovf=0, bad_addr=0.
- Reset mid-operation flushes the FIFO, including any un-popped words, with no further tx_valid. Reset has priority over a same-cycle write or pop.
- Counter reads 0 at the first edge after rst deasserts, then 1, 2, …

## Test plan
- RAM round trip: write 0xBEEF to 0x0010, then 0x1234 to 0x00FF. Read 0x0010 → mem_rdata=0xBEEF one cycle later. Read 0x00FF → 0x1234.
- Counter latch: after rst release, hold 9 cycles, then read CNT_LO then CNT_HI → values consistent with the reset edge; 0x0000 for HI. Force the counter near 0x0000FFFF and read across the wrap → HI shadow is not torn.
- FIFO overflow: tx_ready=0, write 0x0001..0x0005 to TXDATA → STATUS=0x0046 (count 4, full, ovf). Raise tx_ready → tx_data sequence 1,2,3,4, then tx_valid=0 and STATUS=0x0005.
- Simultaneous push/pop: FIFO holds 2 words, TXDATA write while tx_ready=1 → count stays 2, order preserved.
- Unmapped/W1C: write 0x0200 → bad_addr=1 and RAM unchanged; read 0x0200 → 0. Write STATUS=0x000C → bits 2 and 3 clear.
- Reset mid-stream: FIFO holds 3 words and GPIO=0xA5A5, assert rst for 1 cycle → tx_valid=0, gpio_out=0, STATUS=0x0001, mem_rdata=0.

Source files
------------

// File: rtl/data_bus_responder_if.sv
// -----------------------------------------------------------------------------
// data_bus_responder_if
// Bundles the CPU data-memory port, the GPIO output and the TX stream port
// between the CPU/system side (master) and the responder (slave).
//   mem_wr_en  : CPU write strobe, qualifies mem_addr/mem_wdata this cycle
//   mem_addr   : CPU data word address
//   mem_wdata  : CPU write data
//   mem_rdata  : registered read data for the previous cycle's address
//   gpio_out   : GPIO output register
//   tx_data    : TX FIFO head word (0 when empty)
//   tx_valid   : TX FIFO non-empty
//   tx_ready   : sink accepts tx_data when tx_valid & tx_ready
// -----------------------------------------------------------------------------
interface data_bus_responder_if;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] gpio_out;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // CPU / system side: drives the bus and the stream sink's ready
    modport master (
        output mem_wr_en,
        output mem_addr,
        output mem_wdata,
        output tx_ready,
        input  mem_rdata,
        input  gpio_out,
        input  tx_data,
        input  tx_valid
    );

    // Responder side
    modport slave (
        input  mem_wr_en,
        input  mem_addr,
        input  mem_wdata,
        input  tx_ready,
        output mem_rdata,
        output gpio_out,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
// Serves the CPU data port: a 2^RAM_AW-word read-first data RAM at address 0,
// plus an I/O page at IO_BASE:
//   +0 GPIO (R/W), +1 CNT_LO (RO, captures CNT_HI shadow on read),
//   +2 CNT_HI shadow (RO), +3 STATUS (R/W1C), +4 TXDATA (WO, reads 0).
// Read data is registered (1-cycle latency). Writes to TXDATA push into a
// small circular TX FIFO that drains through a valid/ready stream port.
// STATUS = {8'h00, count[3:0], bad_addr, ovf, full, empty}.
// Ports:
//   i_clk : clock, all state changes on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : data_bus_responder_if.slave (CPU port, GPIO, TX stream)
// FIFO_DEPTH must be a power of 2 in the range 2..8.
// -----------------------------------------------------------------------------
module data_bus_responder #(
    parameter int unsigned RAM_AW     = 8,
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    data_bus_responder_if.slave  bus
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);

    // Storage and registers
    logic [15:0]   r_ram  [RAM_WORDS];
    logic [15:0]   r_fifo [FIFO_DEPTH];
    logic [15:0]   r_rdata;
    logic [15:0]   r_gpio;
    logic [15:0]   r_shadow;
    logic [31:0]   r_cnt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [3:0]    r_count;
    logic          r_ovf;
    logic          r_bad;

    // Decode
    logic          w_wr;
    logic          w_in_ram;
    logic          w_sel_gpio;
    logic          w_sel_lo;
    logic          w_sel_hi;
    logic          w_sel_stat;
    logic          w_sel_tx;
    logic          w_unmapped;
    logic [RAM_AW-1:0] w_ram_idx;

    // FIFO / status
    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_bad_set;
    logic          w_stat_wr;
    logic [15:0]   w_status;
    logic [15:0]   w_rdata_nxt;

    // Address decode, evaluated every cycle since there is no read strobe
    assign w_wr       = bus.mem_wr_en;
    assign w_in_ram   = (bus.mem_addr >> RAM_AW) == 16'h0000;
    assign w_sel_gpio = bus.mem_addr == IO_BASE;
    assign w_sel_lo   = bus.mem_addr == (IO_BASE + 16'd1);
    assign w_sel_hi   = bus.mem_addr == (IO_BASE + 16'd2);
    assign w_sel_stat = bus.mem_addr == (IO_BASE + 16'd3);
    assign w_sel_tx   = bus.mem_addr == (IO_BASE + 16'd4);
    assign w_unmapped = !(w_in_ram | w_sel_gpio | w_sel_lo | w_sel_hi |
                          w_sel_stat | w_sel_tx);
    assign w_ram_idx  = bus.mem_addr[RAM_AW-1:0];

    // FIFO control; full/ovf decisions use the count at cycle start
    assign w_empty    = r_count == 4'd0;
    assign w_full     = r_count == 4'(FIFO_DEPTH);
    assign w_push_req = w_wr & w_sel_tx;
    assign w_push     = w_push_req & ~w_full;
    assign w_ovf_set  = w_push_req & w_full;
    assign w_pop      = ~w_empty & bus.tx_ready;
    assign w_bad_set  = w_wr & w_unmapped;
    assign w_stat_wr  = w_wr & w_sel_stat;

    assign w_status   = {8'h00, r_count, r_bad, r_ovf, w_full, w_empty};

    // Read-data mux; TXDATA and unmapped addresses read as 0
    always_comb begin
        w_rdata_nxt = 16'h0000;
        if (w_in_ram) begin
            w_rdata_nxt = r_ram[w_ram_idx];
        end else if (w_sel_gpio) begin
            w_rdata_nxt = r_gpio;
        end else if (w_sel_lo) begin
            w_rdata_nxt = r_cnt[15:0];
        end else if (w_sel_hi) begin
            w_rdata_nxt = r_shadow;
        end else if (w_sel_stat) begin
            w_rdata_nxt = w_status;
        end
    end

    // Data RAM: not reset, read-first (read path samples pre-edge contents)
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr && w_in_ram) begin
            r_ram[w_ram_idx] <= bus.mem_wdata;
        end
    end

    // FIFO storage: not reset, validity is tracked by pointers/count
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_fifo[r_wptr] <= bus.mem_wdata;
        end
    end

    // Control and status registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata  <= 16'h0000;
            r_gpio   <= 16'h0000;
            r_shadow <= 16'h0000;
            r_cnt    <= 32'h0000_0000;
            r_wptr   <= PW'(0);
            r_rptr   <= PW'(0);
            r_count  <= 4'd0;
            r_ovf    <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_rdata <= w_rdata_nxt;
            r_cnt   <= r_cnt + 32'd1;

            // Reading CNT_LO freezes the high half so a later CNT_HI read is coherent
            if (w_sel_lo && !w_wr) begin
                r_shadow <= r_cnt[31:16];
            end

            if (w_wr && w_sel_gpio) begin
                r_gpio <= bus.mem_wdata;
            end

            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase

            // Sticky flags, W1C; a same-cycle set beats the clear
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr && bus.mem_wdata[2]) begin
                r_ovf <= 1'b0;
            end

            if (w_bad_set) begin
                r_bad <= 1'b1;
            end else if (w_stat_wr && bus.mem_wdata[3]) begin
                r_bad <= 1'b0;
            end
        end
    end

    assign bus.mem_rdata = r_rdata;
    assign bus.gpio_out  = r_gpio;
    assign bus.tx_valid  = ~w_empty;
    assign bus.tx_data   = w_empty ? 16'h0000 : r_fifo[r_rptr];

endmodule
